// File: rtl/psram_ram_arb.sv
// Three-requester round-robin arbiter (dma_rd, trx_rd, trx_wr) in front of a single-port RAM.
// Only one access is in flight at a time, and a BUSY access is bounded by a cycle timeout.
module psram_ram_arb #(
  parameter int AW  = 16,
  parameter int TMO = 255
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          dma_rd_req,
  input  logic          trx_rd_req,
  input  logic          trx_wr_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [AW-1:0] trx_rd_addr,
  input  logic [AW-1:0] trx_wr_addr,
  input  logic [31:0]   trx_wdata,
  output logic          dma_rd_ack,
  output logic          trx_rd_ack,
  output logic          trx_wr_ack,
  output logic [31:0]   rd_data,
  output logic          ram_rd_req,
  output logic          ram_wr_req,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic          ram_rd_ack,
  input  logic          ram_wr_ack,
  input  logic [31:0]   ram_rdata,
  output logic          tmo_err,
  output logic [1:0]    tmo_src
);

  // IDLE: arbitrate | BUSY: RAM access in flight | DONE: requester ack cycle
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OWN_DMA = 2'd0;
  localparam logic [1:0] OWN_TRD = 2'd1;
  localparam logic [1:0] OWN_TWR = 2'd2;

  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  logic [1:0]    r_state;
  logic [1:0]    r_owner;
  logic [1:0]    r_start;
  logic          r_mask_vld;
  logic [15:0]   r_cnt;
  logic          r_ram_rd_req;
  logic          r_ram_wr_req;
  logic [AW-1:0] r_ram_addr;
  logic [31:0]   r_ram_wdata;
  logic [31:0]   r_rd_data;
  logic          r_dma_ack;
  logic          r_trx_rd_ack;
  logic          r_trx_wr_ack;
  logic          r_tmo_err;
  logic [1:0]    r_tmo_src;

  logic [2:0]    w_req;
  logic [2:0]    w_mask;
  logic [2:0]    w_req_m;
  logic [1:0]    w_o0;
  logic [1:0]    w_o1;
  logic [1:0]    w_o2;
  logic          w_gnt_vld;
  logic [1:0]    w_gnt_idx;
  logic [1:0]    w_nxt;
  logic [AW-1:0] w_gnt_addr;
  logic          w_own_rd;
  logic          w_match;
  logic          w_tmo;

  assign w_req = {trx_wr_req, trx_rd_req, dma_rd_req};

  // The requester that was just acked may still hold its request for one IDLE cycle.
  assign w_mask  = r_mask_vld ? (3'b001 << r_owner) : 3'b000;
  assign w_req_m = w_req & ~w_mask;

  always_comb begin
    w_o0 = OWN_DMA;
    w_o1 = OWN_TRD;
    w_o2 = OWN_TWR;
    case (r_start)
      OWN_TRD: begin
        w_o0 = OWN_TRD;
        w_o1 = OWN_TWR;
        w_o2 = OWN_DMA;
      end
      OWN_TWR: begin
        w_o0 = OWN_TWR;
        w_o1 = OWN_DMA;
        w_o2 = OWN_TRD;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_gnt_vld = 1'b1;
    w_gnt_idx = w_o0;
    if (w_req_m[w_o0]) begin
      w_gnt_idx = w_o0;
    end else if (w_req_m[w_o1]) begin
      w_gnt_idx = w_o1;
    end else if (w_req_m[w_o2]) begin
      w_gnt_idx = w_o2;
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_nxt = (w_gnt_idx == OWN_TWR) ? OWN_DMA : (w_gnt_idx + 2'd1);

  always_comb begin
    w_gnt_addr = dma_addr;
    case (w_gnt_idx)
      OWN_TRD: w_gnt_addr = trx_rd_addr;
      OWN_TWR: w_gnt_addr = trx_wr_addr;
      default: w_gnt_addr = dma_addr;
    endcase
  end

  assign w_own_rd = (r_owner != OWN_TWR);
  assign w_match  = w_own_rd ? ram_rd_ack : ram_wr_ack;
  assign w_tmo    = (r_cnt == TMO_LAST);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_DMA;
      r_start      <= OWN_DMA;
      r_mask_vld   <= 1'b0;
      r_cnt        <= 16'd0;
      r_ram_rd_req <= 1'b0;
      r_ram_wr_req <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= 32'd0;
      r_rd_data    <= 32'd0;
      r_dma_ack    <= 1'b0;
      r_trx_rd_ack <= 1'b0;
      r_trx_wr_ack <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_tmo_src    <= 2'd0;
    end else begin
      r_dma_ack    <= 1'b0;
      r_trx_rd_ack <= 1'b0;
      r_trx_wr_ack <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_mask_vld   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_owner      <= w_gnt_idx;
            r_start      <= w_nxt;
            r_ram_addr   <= w_gnt_addr;
            r_ram_wdata  <= trx_wdata;
            r_ram_rd_req <= (w_gnt_idx != OWN_TWR);
            r_ram_wr_req <= (w_gnt_idx == OWN_TWR);
            r_cnt        <= 16'd0;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A matching ack wins over a timeout landing in the same cycle.
          if (w_match || w_tmo) begin
            r_ram_rd_req <= 1'b0;
            r_ram_wr_req <= 1'b0;
            r_dma_ack    <= (r_owner == OWN_DMA);
            r_trx_rd_ack <= (r_owner == OWN_TRD);
            r_trx_wr_ack <= (r_owner == OWN_TWR);
            r_state      <= ST_DONE;
            if (w_match) begin
              if (w_own_rd) r_rd_data <= ram_rdata;
            end else begin
              r_tmo_err <= 1'b1;
              r_tmo_src <= r_owner;
              if (w_own_rd) r_rd_data <= 32'd0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_mask_vld <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_rd_ack = r_dma_ack;
  assign trx_rd_ack = r_trx_rd_ack;
  assign trx_wr_ack = r_trx_wr_ack;
  assign rd_data    = r_rd_data;
  assign ram_rd_req = r_ram_rd_req;
  assign ram_wr_req = r_ram_wr_req;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign tmo_err    = r_tmo_err;
  assign tmo_src    = r_tmo_src;

endmodule

// File: tb/tb_psram_ram_arb.sv
// Directed bench for psram_ram_arb: latency, round-robin order, timeout, ack/timeout race, reset abort.
module tb_psram_ram_arb;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic          hclk = 1'b0;
  logic          hrst = 1'b1;
  logic          dma_rd_req = 1'b0, trx_rd_req = 1'b0, trx_wr_req = 1'b0;
  logic [AW-1:0] dma_addr = '0, trx_rd_addr = '0, trx_wr_addr = '0;
  logic [31:0]   trx_wdata = 32'd0;
  logic          dma_rd_ack, trx_rd_ack, trx_wr_ack;
  logic [31:0]   rd_data;
  logic          ram_rd_req, ram_wr_req;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_rd_ack = 1'b0, ram_wr_ack = 1'b0;
  logic [31:0]   ram_rdata = 32'd0;
  logic          tmo_err;
  logic [1:0]    tmo_src;
  logic [2:0]    w_acks;

  int n_tot = 0;
  int n_bad = 0;

  psram_ram_arb #(.AW(AW), .TMO(TMO)) dut (
    .hclk(hclk), .hrst(hrst),
    .dma_rd_req(dma_rd_req), .trx_rd_req(trx_rd_req), .trx_wr_req(trx_wr_req),
    .dma_addr(dma_addr), .trx_rd_addr(trx_rd_addr), .trx_wr_addr(trx_wr_addr),
    .trx_wdata(trx_wdata),
    .dma_rd_ack(dma_rd_ack), .trx_rd_ack(trx_rd_ack), .trx_wr_ack(trx_wr_ack),
    .rd_data(rd_data),
    .ram_rd_req(ram_rd_req), .ram_wr_req(ram_wr_req),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rd_ack(ram_rd_ack), .ram_wr_ack(ram_wr_ack), .ram_rdata(ram_rdata),
    .tmo_err(tmo_err), .tmo_src(tmo_src)
  );

  assign w_acks = {trx_wr_ack, trx_rd_ack, dma_rd_ack};

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic reset_dut();
    hrst = 1'b1;
    tick();
    tick();
    hrst = 1'b0;
  endtask

  // Waits for a grant, checks it, answers after lat cycles and checks the requester ack.
  task automatic serve(input int own, input logic [AW-1:0] addr, input logic [31:0] rdat, input int lat);
    int n = 0;
    while (!(ram_rd_req || ram_wr_req) && n < 10) begin
      tick();
      n++;
    end
    chk("gnt_seen", 32'(ram_rd_req | ram_wr_req), 32'd1);
    chk("gnt_rd", 32'(ram_rd_req), (own != 2) ? 32'd1 : 32'd0);
    chk("gnt_wr", 32'(ram_wr_req), (own == 2) ? 32'd1 : 32'd0);
    chk("gnt_addr", 32'(ram_addr), 32'(addr));
    if (own == 2) chk("gnt_wdata", ram_wdata, 32'hDEAD_BEEF);
    repeat (lat) tick();
    if (own == 2) ram_wr_ack = 1'b1;
    else ram_rd_ack = 1'b1;
    ram_rdata = rdat;
    tick();
    ram_rd_ack = 1'b0;
    ram_wr_ack = 1'b0;
    ram_rdata  = 32'd0;
    chk("req_ack", 32'(w_acks), 32'd1 << own);
    if (own != 2) chk("rd_data", rd_data, rdat);
    chk("ram_req_drop", 32'(ram_rd_req | ram_wr_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    trx_wdata = 32'hDEAD_BEEF;
    reset_dut();
    chk("rst_rd_req", 32'(ram_rd_req), 32'd0);
    chk("rst_wr_req", 32'(ram_wr_req), 32'd0);
    chk("rst_acks", 32'(w_acks), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);

    // Single DMA read, RAM answers three cycles after the grant
    dma_addr = 16'h0010;
    dma_rd_req = 1'b1;
    tick();
    chk("t1_rd_req_lat", 32'(ram_rd_req), 32'd1);
    chk("t1_wr_req", 32'(ram_wr_req), 32'd0);
    chk("t1_addr", 32'(ram_addr), 32'h0010);
    tick();
    tick();
    chk("t1_rd_req_hold", 32'(ram_rd_req), 32'd1);
    ram_rd_ack = 1'b1;
    ram_rdata  = 32'hA5A5_0001;
    tick();
    ram_rd_ack = 1'b0;
    ram_rdata  = 32'd0;
    chk("t1_dma_ack", 32'(w_acks), 32'd1);
    chk("t1_rd_data", rd_data, 32'hA5A5_0001);
    chk("t1_rd_req_drop", 32'(ram_rd_req), 32'd0);
    tick();
    chk("t1_ack_pulse", 32'(w_acks), 32'd0);
    tick();
    dma_rd_req = 1'b0;
    chk("t1_no_regrant", 32'(ram_rd_req), 32'd0);
    tick();

    // Timeout on trx_rd; request withdrawn mid-access must still be acked
    trx_rd_addr = 16'h0055;
    trx_rd_req = 1'b1;
    tick();
    trx_rd_req = 1'b0;
    n = 0;
    while (ram_rd_req && n < 20) begin
      n++;
      tick();
    end
    chk("t3_busy_cycles", 32'(n), 32'd8);
    chk("t3_tmo_err", 32'(tmo_err), 32'd1);
    chk("t3_tmo_src", 32'(tmo_src), 32'd1);
    chk("t3_trx_rd_ack", 32'(w_acks), 32'd2);
    chk("t3_rd_data_zero", rd_data, 32'd0);
    tick();
    chk("t3_tmo_pulse", 32'(tmo_err), 32'd0);
    chk("t3_tmo_src_hold", 32'(tmo_src), 32'd1);
    tick();

    // Matching ack on the timeout cycle counts as a normal completion
    dma_addr = 16'h0020;
    dma_rd_req = 1'b1;
    tick();
    chk("t4_rd_req", 32'(ram_rd_req), 32'd1);
    repeat (7) tick();
    chk("t4_rd_req_last", 32'(ram_rd_req), 32'd1);
    ram_rd_ack = 1'b1;
    ram_rdata  = 32'h1234_5678;
    tick();
    ram_rd_ack = 1'b0;
    ram_rdata  = 32'd0;
    dma_rd_req = 1'b0;
    chk("t4_dma_ack", 32'(w_acks), 32'd1);
    chk("t4_no_tmo", 32'(tmo_err), 32'd0);
    chk("t4_rd_data", rd_data, 32'h1234_5678);
    tick();
    tick();

    // Write ack while a read owns the RAM is ignored
    trx_rd_addr = 16'h0066;
    trx_rd_req = 1'b1;
    tick();
    trx_rd_req = 1'b0;
    ram_wr_ack = 1'b1;
    tick();
    tick();
    ram_wr_ack = 1'b0;
    chk("t5_rd_req_held", 32'(ram_rd_req), 32'd1);
    chk("t5_no_ack", 32'(w_acks), 32'd0);
    ram_rd_ack = 1'b1;
    ram_rdata  = 32'hCAFE_0005;
    tick();
    ram_rd_ack = 1'b0;
    ram_rdata  = 32'd0;
    chk("t5_trx_rd_ack", 32'(w_acks), 32'd2);
    chk("t5_rd_data", rd_data, 32'hCAFE_0005);
    chk("t5_no_tmo", 32'(tmo_err), 32'd0);
    tick();

    // Reset in the middle of a trx_rd access; pointer restarts at dma_rd
    trx_rd_addr = 16'h0077;
    trx_rd_req = 1'b1;
    n = 0;
    while (!ram_rd_req && n < 10) begin
      tick();
      n++;
    end
    chk("t6_busy", 32'(ram_rd_req), 32'd1);
    chk("t6_addr", 32'(ram_addr), 32'h0077);
    trx_rd_req = 1'b0;
    dma_addr = 16'h0030;
    dma_rd_req = 1'b1;
    trx_wr_addr = 16'h0300;
    trx_wr_req = 1'b1;
    tick();
    #2;
    hrst = 1'b1;
    #1;
    chk("t6_rst_rd_req", 32'(ram_rd_req), 32'd0);
    chk("t6_rst_addr", 32'(ram_addr), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'd0);
    chk("t6_rst_tmo_src", 32'(tmo_src), 32'd0);
    tick();
    tick();
    chk("t6_rst_no_ack", 32'(w_acks), 32'd0);
    hrst = 1'b0;
    serve(0, 16'h0030, 32'h0BAD_0006, 1);
    dma_rd_req = 1'b0;
    trx_wr_req = 1'b0;
    tick();

    // All three held from reset: dma_rd, trx_rd, trx_wr, dma_rd
    reset_dut();
    dma_addr = 16'h0100;
    trx_rd_addr = 16'h0200;
    trx_wr_addr = 16'h0300;
    dma_rd_req = 1'b1;
    trx_rd_req = 1'b1;
    trx_wr_req = 1'b1;
    serve(0, 16'h0100, 32'h1111_0000, 1);
    serve(1, 16'h0200, 32'h2222_0000, 2);
    serve(2, 16'h0300, 32'h0000_0000, 0);
    serve(0, 16'h0100, 32'h4444_0000, 3);
    dma_rd_req = 1'b0;
    trx_rd_req = 1'b0;
    trx_wr_req = 1'b0;
    tick();
    tick();
    chk("t2_idle", 32'(ram_rd_req | ram_wr_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/psram_ram_arb.md
PSRAM_RAM_ARB -- requirements
Module: psram_ram_arb

Interface
REQ-001 SHALL have parameter AW, default 16, RAM word-address width.
REQ-002 SHALL have parameter TMO, default 255, BUSY-cycle timeout limit (1..65535).
REQ-003 SHALL have port hclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port hrst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports dma_rd_req/trx_rd_req/trx_wr_req, input, 1 each, level requests held until own ack.
REQ-006 SHALL have ports dma_addr/trx_rd_addr/trx_wr_addr, input, AW each, request addresses.
REQ-007 SHALL have port trx_wdata, input, 32, write data for trx_wr.
REQ-008 SHALL have ports dma_rd_ack/trx_rd_ack/trx_wr_ack, output, 1 each, one-cycle completion pulses.
REQ-009 SHALL have port rd_data, output, 32, captured read data, valid with a read ack.
REQ-010 SHALL have ports ram_rd_req/ram_wr_req, output, 1 each; ram_addr, output, AW; ram_wdata, output, 32.
REQ-011 SHALL have ports ram_rd_ack/ram_wr_ack, input, 1 each; ram_rdata, input, 32.
REQ-012 SHALL have port tmo_err, output, 1, one-cycle pulse on timeout; tmo_src, output, 2, owner index of last timeout.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: if any request high, SHALL grant one by round-robin, latch owner, address, wdata, go BUSY; else stay IDLE.
REQ-015 Round-robin index: 0=dma_rd, 1=trx_rd, 2=trx_wr; search SHALL start at (last owner+1) mod 3; after reset search starts at 0.
REQ-016 BUSY: ram_rd_req (owner 0/1) or ram_wr_req (owner 2) SHALL be high, registered, with ram_addr/ram_wdata stable throughout BUSY.
REQ-017 Grant-to-RAM latency SHALL be 1 cycle: request sampled in IDLE at cycle N -> ram_*_req high at N+1.
REQ-018 BUSY: matching RAM ack (ram_rd_ack for read owner, ram_wr_ack for write owner) SHALL drop ram_*_req next cycle and go DONE; non-matching ack SHALL be ignored.
REQ-019 On read completion SHALL capture ram_rdata into rd_data on the ack cycle; rd_data holds until next read completion.
REQ-020 DONE: owner's ack output SHALL be high for exactly this one cycle, then IDLE; no grant in DONE.
REQ-021 Requester SHALL drop request by the cycle after its ack; arbiter SHALL not re-grant the same owner on a request dropped in that cycle.
REQ-022 BUSY cycle counter (16 bit) SHALL clear on BUSY entry; on reaching TMO without matching ack SHALL drop ram_*_req, pulse tmo_err, set tmo_src=owner, force rd_data=0 if read, go DONE.
REQ-023 Simultaneous matching ack and timeout in same cycle SHALL be treated as normal completion, no tmo_err.
REQ-024 Request deasserted while owner in BUSY SHALL not abort the RAM access; ack still issued.
REQ-025 At most one of ram_rd_req/ram_wr_req SHALL be high in any cycle; at most one requester ack high in any cycle.

Reset
REQ-026 hrst high SHALL asynchronously force state IDLE, pointer 0, all ram_*_req, acks, tmo_err low, ram_addr/ram_wdata/rd_data 0, tmo_src 0, counter 0.
REQ-027 hrst asserted mid-BUSY SHALL abandon the access with no ack; first grant after release follows REQ-015 reset order.

Verification
REQ-028 Single read: dma_rd_req=1, dma_addr=0x0010, RAM ack 3 cycles later with 0xA5A5_0001 -> ram_rd_req 1 cycle after req, dma_rd_ack pulse, rd_data=0xA5A5_0001.
REQ-029 All three requests held from reset -> grant order dma_rd, trx_rd, trx_wr, dma_rd; ram_wr_req only on trx_wr grant with ram_wdata=trx_wdata.
REQ-030 RAM never acks, TMO=8 -> ram_rd_req high 8 cycles, tmo_err 1-cycle pulse, tmo_src=owner, owner ack pulse with rd_data=0.
REQ-031 Ack and timeout on same cycle -> normal ack, tmo_err stays 0, rd_data=ram_rdata.
REQ-032 hrst pulsed during BUSY -> all outputs 0 immediately, no ack, next grant to dma_rd if requesting.
REQ-033 ram_wr_ack during read ownership -> ignored, access continues until ram_rd_ack or timeout.
